// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the MEM-stage data memory.
//   size_e   access size encoding (req_size)
//   state_e  controller FSM states
//   byte_en  lane mask for an access; lane k holds byte offset k (big-endian)
//   init_word power-up word contents at an aligned address
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic [3:0] byte_en(size_e size, logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] init_word(logic [31:0] addr);
    logic [31:0] a4;
    a4 = addr + 32'd4;
    return {24'b0, a4[7:0]};
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one byte lane of the data memory, 2**AW x 8, write enable and
// registered read sharing one address.
//   clk    clock
//   we     write enable
//   addr   word index
//   wdata  byte to write
//   rdata  registered read byte (old contents when written on the same edge)
// LANE picks which byte of init_word() this bank powers up with.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int AW   = 8,
  parameter int LANE = 0
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  localparam int DEPTH = 2 ** AW;
  typedef logic [7:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w    = init_word(32'(i) << 2);
      m[i] = w[31-8*LANE -: 8];
    end
    return m;
  endfunction

  // Contents come from the power-up image only; reset never touches them.
  mem_t mem = init_mem();

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed big-endian data memory for the MEM stage.
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake, one request outstanding
//   req_we            1 store / 0 load
//   req_size          00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned      zero-extend loads when set
//   req_addr          byte address, wraps modulo 2**ADDR_W
//   req_wdata         right-aligned store data
//   rsp_valid         one-cycle response pulse, WAIT_STATES+1 cycles after accept
//   rsp_rdata         extended load data, 0 for stores and errors
//   misalign_err      error flag qualifying rsp_valid
// Build option DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// reported with misalign_err instead of being silently aligned.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              misalign_err
);

  localparam int WAW = ADDR_W - 2;

  state_e         state, state_nx;
  logic [3:0]     cnt;
  logic           acc, last;
  size_e          sz, size_q;
  logic [1:0]     off, off_q;
  logic           err, err_q, we_q, uns_q;
  logic [WAW-1:0] widx_q, bank_addr;
  logic [3:0]     be;
  logic [3:0][7:0] lane_wd, lane_rd;
  logic [31:0]    word, ext;
  logic [7:0]     bsel;
  logic [15:0]    hsel;
  logic           unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W];

  assign sz = size_e'(req_size);

  always_comb begin
    off = req_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    err = (sz == SZ_RSV) || (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
`else
    if (sz == SZ_H) off[0] = 1'b0;
    if (sz == SZ_W) off    = 2'b00;
    err = (sz == SZ_RSV);
`endif
  end

  assign req_ready = rst_n && (state == IDLE || state == RESP);
  assign acc       = req_valid && req_ready;
  assign last      = (state == WAIT) && (cnt == 4'(WAIT_STATES - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (last) state_nx = RESP;
      RESP:    state_nx = acc ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= SZ_B;
      off_q  <= '0;
      widx_q <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        cnt    <= '0;
        err_q  <= err;
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= sz;
        off_q  <= off;
        widx_q <= req_addr[ADDR_W-1:2];
      end else if (state == WAIT) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // The banks are read on every edge; the edge that enters RESP is either
  // the accept edge (no wait states, request address) or the last WAIT
  // edge (latched address). Earlier stores are already in the array.
  assign bank_addr = (state == WAIT) ? widx_q : req_addr[ADDR_W-1:2];
  assign be        = byte_en(sz, off);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane_wd[k] = (sz == SZ_B) ? req_wdata[7:0] :
                        (sz == SZ_H) ? req_wdata[15-8*(k%2) -: 8] :
                                       req_wdata[31-8*k -: 8];
    dmem_bank #(.AW(WAW), .LANE(k)) u_bank (
      .clk   (clk),
      .we    (acc && req_we && !err && be[k]),
      .addr  (bank_addr),
      .wdata (lane_wd[k]),
      .rdata (lane_rd[k])
    );
  end

  assign word = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};

  always_comb begin
    case (off_q)
      2'd0:    bsel = word[31:24];
      2'd1:    bsel = word[23:16];
      2'd2:    bsel = word[15:8];
      default: bsel = word[7:0];
    endcase
    hsel = off_q[1] ? word[15:0] : word[31:16];
    case (size_q)
      SZ_B:    ext = uns_q ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      SZ_H:    ext = uns_q ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      SZ_W:    ext = word;
      default: ext = '0;
    endcase
  end

  assign rsp_valid    = (state == RESP);
  assign misalign_err = rsp_valid && err_q;
  assign rsp_rdata    = (rsp_valid && !we_q && !err_q) ? ext : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: two dmem_ctrl instances (WAIT_STATES 0 and 3) checked against
// a byte-array reference model; directed cases followed by random traffic.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic        req_uns   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        mis_err   [2];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  mem_m [2][1024];
  logic [31:0] exp_rd;
  logic        exp_err;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_uns[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .misalign_err(mis_err[0]));

  dmem_ctrl #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_uns[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .misalign_err(mis_err[1]));

  function automatic int ws(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: bytes in address order, big-endian assembly, commit at accept.
  task automatic model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [9:0]  a;
    logic [31:0] v;
    int nb;
    a       = addr[9:0];
    exp_rd  = 32'h0;
    exp_err = 1'b0;
    if (sz == 2'd3) begin exp_err = 1'b1; return; end
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) begin
      exp_err = 1'b1;
      return;
    end
`else
    if (sz == 2'd1) a[0] = 1'b0;
    if (sz == 2'd2) a[1:0] = 2'b00;
`endif
    nb = 1 << sz;
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[d][a + 10'(i)] = wd[8*(nb-1-i) +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mem_m[d][a + 10'(i)]);
      if (!uns && nb == 1) v = {{24{v[7]}}, v[7:0]};
      if (!uns && nb == 2) v = {{16{v[15]}}, v[15:0]};
      exp_rd = v;
    end
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit now);
    int n;
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz; req_uns[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wd;
    #1;
    if (now) chk("rdy_b2b", 32'(req_ready[d]), 32'd1);
    n = 0;
    while (!req_ready[d] && n < 40) begin @(negedge clk); #1; n++; end
    if (n >= 40) chk("acc_tmo", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    model(d, we, sz, uns, addr, wd);
  endtask

  // Holds req_valid until the response; returns at the response negedge.
  task automatic finish(input int d, output logic [31:0] rd, output logic er);
    int k;
    bit got;
    k = 0; got = 0; rd = 'x; er = 1'bx;
    while (!got && k < ws(d) + 4) begin
      @(negedge clk);
      k++;
      if (rsp_valid[d]) got = 1;
      else if (k <= ws(d)) chk("rdy_wait", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    if (!got) begin
      chk("rsp_tmo", 32'(rsp_valid[d]), 32'd1);
      return;
    end
    rd = rsp_rdata[d]; er = mis_err[d];
    chk("latency", 32'(k), 32'(ws(d) + 1));
    chk("rdata", rd, exp_rd);
    chk("err", 32'(er), 32'(exp_err));
    chk("rdy_resp", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic run(input int d, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    issue(d, we, sz, uns, addr, wd, 1'b0);
    finish(d, rd, er);
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk); #1;
      chk("rsp_idle", 32'(rsp_valid[d]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [1:0]  sz;
    logic [31:0] a;
    int r;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) mem_m[d][i] = ((i % 4) == 3) ? 8'(i + 1) : 8'h00;
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_uns[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_err", 32'(mis_err[d]), 32'd0);
      chk("rst_ready", 32'(req_ready[d]), 32'd0);
      rst_n[d] = 1'b1;
    end
    @(negedge clk);

    // Power-up image and big-endian lanes/extension (no wait states).
    run(0, 0, 2'd2, 0, 32'h000, 0, rd, er); chk("t1_lw000", rd, 32'h00000004);
    run(0, 0, 2'd2, 0, 32'h01C, 0, rd, er); chk("t1_lw01c", rd, 32'h00000020);
    run(0, 1, 2'd2, 0, 32'h040, 32'h8899AABB, rd, er); chk("t2_sw", rd, 32'h0);
    run(0, 0, 2'd0, 1, 32'h040, 0, rd, er); chk("t2_lbu", rd, 32'h00000088);
    run(0, 0, 2'd0, 0, 32'h043, 0, rd, er); chk("t2_lb", rd, 32'hFFFFFFBB);
    run(0, 0, 2'd1, 1, 32'h042, 0, rd, er); chk("t2_lhu", rd, 32'h0000AABB);
    run(0, 0, 2'd1, 0, 32'h040, 0, rd, er); chk("t2_lh", rd, 32'hFFFF8899);

    // Store then load back-to-back with no bubble.
    issue(0, 1, 2'd0, 0, 32'h041, 32'h00000012, 1'b0);
    finish(0, rd, er);
    issue(0, 0, 2'd2, 0, 32'h040, 0, 1'b1);
    finish(0, rd, er); chk("t3_b2b", rd, 32'h8812AABB);
    idle(0, 2);

    // Misaligned half.
    run(0, 1, 2'd2, 0, 32'h100, 32'h11223344, rd, er);
    run(0, 0, 2'd1, 0, 32'h101, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("t5_mis_rd", rd, 32'h0); chk("t5_mis_err", 32'(er), 32'd1);
`else
    chk("t5_mis_rd", rd, 32'h00001122); chk("t5_mis_err", 32'(er), 32'd0);
`endif
    run(0, 0, 2'd2, 0, 32'h100, 0, rd, er); chk("t5_mem", rd, 32'h11223344);
    run(0, 0, 2'd3, 0, 32'h104, 0, rd, er); chk("t5_rsv_err", 32'(er), 32'd1);

    // Wait states: ready low during WAIT, response on the 4th cycle.
    run(1, 0, 2'd2, 0, 32'h004, 0, rd, er); chk("t4_lw004", rd, 32'h00000008);
    idle(1, 1);

    // Reset in WAIT of a load drops the response.
    issue(1, 0, 2'd2, 0, 32'h000, 0, 1'b0);
    @(negedge clk);
    rst_n[1] = 1'b0; req_valid[1] = 1'b0;
    #1 chk("t6_rdy_rst", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    idle(1, 6);

    // Reset in WAIT of a store keeps the store; read it through the wrap.
    issue(1, 1, 2'd2, 0, 32'h3FC, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    rst_n[1] = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    idle(1, 5);
    run(1, 0, 2'd2, 0, 32'h7FC, 0, rd, er); chk("t6_wrap", rd, 32'hCAFEF00D);

    // Random traffic on both configurations.
    for (int d = 0; d < 2; d++) begin
      idle(d, 1);
      for (int it = 0; it < 150; it++) begin
        r  = $urandom_range(0, 9);
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        a  = ($urandom_range(0, 2) != 0) ? (32'h40 + 32'($urandom_range(0, 31))) : $urandom;
        issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
              1'b0);
        finish(d, rd, er);
        if ($urandom_range(0, 1) != 0) idle(d, $urandom_range(1, 2));
      end
      idle(d, 2);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
